qdec_bitstream_fetch: RTL and testbench

Byte-stream source for the CABAC decoder's `bitstreamFetch` valid/ready input. On a start command it reads a slice's bitstream from external RAM as 32-bit words, buffers them in a small word FIFO, unpacks them into bytes in stream order, and optionally removes HEVC emulation-prevention bytes (0x000003 → 0x0000). It sits between the system RAM port and `qdec_cabac`, and is the producer end of the interface that the decoder consumes.

---
 rtl/qdec_bitstream_fetch.sv | 224 ++++++++++++++++++++++
 tb/tb_qdec_bitstream_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_bitstream_fetch.sv
// qdec_bitstream_fetch
//   Reads a slice bitstream from RAM as 32-bit words, buffers the words in a
//   small FIFO, unpacks them MSB-byte-first and presents them on the
//   bitstreamFetch valid/ready stage consumed by qdec_cabac. Optionally strips
//   HEVC emulation-prevention bytes (00 00 03 -> 00 00).
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle command pulse (ignored while busy)
//   base_addr, byte_len   slice location and raw length in bytes
//   epb_en                emulation-prevention removal, sampled at start
//   mem_rd_req/addr/gnt   word read request port (held until granted)
//   mem_rd_data(_vld)     in-order read data return
//   bitstreamFetch(_vld)  output byte stage, bitstreamFetch_rdy from consumer
//   busy, done            status: busy while fetching, done one-cycle pulse
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | issuing word reads, unpacking returned words
// DRAIN  | all reads issued, unpacking remaining bytes
// FINISH | done pulse; a coincident start launches the next slice
module qdec_bitstream_fetch #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_len,
  input  logic              epb_en,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_data_vld,
  output logic [7:0]        bitstreamFetch,
  output logic              bitstreamFetch_vld,
  input  logic              bitstreamFetch_rdy,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic              epb_q;
  logic [LEN_W-1:0]  words_total_q;
  logic [LEN_W-1:0]  req_cnt_q;
  logic [LEN_W-1:0]  raw_cnt_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [1:0]        byte_idx_q;
  logic [1:0]        zero_run_q;
  logic [7:0]        out_data_q;
  logic              out_vld_q;
  logic              busy_q;
  logic              done_q;

  logic              active;
  logic [CNT_W:0]    occ;
  logic              grant;
  logic              wr_en;
  logic [31:0]       head_word;
  logic [7:0]        head_byte;
  logic              byte_avail;
  logic              drop;
  logic              out_free;
  logic              pop_byte;
  logic              load_out;
  logic              last_byte;
  logic              pop_word;
  logic              start_ok;
  logic [1:0]        zero_run_d;

  assign active = (state_q == FETCH) || (state_q == DRAIN);
  // Words in the FIFO plus words still in flight bound the FIFO fill level,
  // so gating requests on this sum makes overflow impossible.
  assign occ    = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};

  // Decoded from registered state only: req/addr cannot change until a grant
  // advances req_cnt_q, and a data return moves one word from in-flight to
  // FIFO without changing occ.
  assign mem_rd_req  = (state_q == FETCH) && (req_cnt_q < words_total_q) &&
                       (occ < (CNT_W+1)'(FIFO_DEPTH));
  assign mem_rd_addr = (base_q & ~ADDR_W'(3)) + ADDR_W'({req_cnt_q, 2'b00});

  assign grant = mem_rd_req && mem_rd_gnt;
  // Returns outside an active transfer belong to requests cut off by reset.
  assign wr_en = mem_rd_data_vld && active;

  assign head_word = fifo_q[rd_ptr_q];
  always_comb begin
    head_byte = head_word[31:24];
    case (byte_idx_q)
      2'd1:    head_byte = head_word[23:16];
      2'd2:    head_byte = head_word[15:8];
      2'd3:    head_byte = head_word[7:0];
      default: head_byte = head_word[31:24];
    endcase
  end

  assign byte_avail = active && (fifo_cnt_q != '0) && (raw_cnt_q != len_q);
  assign drop       = epb_q && (head_byte == 8'h03) && (zero_run_q == 2'd2);
  assign out_free   = !out_vld_q || bitstreamFetch_rdy;
  // A dropped byte needs no room in the output stage.
  assign pop_byte   = byte_avail && (drop || out_free);
  assign load_out   = byte_avail && !drop && out_free;
  assign last_byte  = (raw_cnt_q + LEN_W'(1)) == len_q;
  assign pop_word   = pop_byte && ((byte_idx_q == 2'd3) || last_byte);
  assign start_ok   = start && ((state_q == IDLE) || (state_q == FINISH));

  always_comb begin
    zero_run_d = zero_run_q;
    if (byte_avail && drop)
      zero_run_d = 2'd0;
    else if (load_out)
      zero_run_d = (head_byte != 8'h00) ? 2'd0 :
                   (zero_run_q == 2'd2) ? 2'd2 : zero_run_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      epb_q         <= 1'b0;
      words_total_q <= '0;
      req_cnt_q     <= '0;
      raw_cnt_q     <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      byte_idx_q    <= '0;
      zero_run_q    <= '0;
      out_data_q    <= '0;
      out_vld_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (load_out) begin
        out_data_q <= head_byte;
        out_vld_q  <= 1'b1;
      end else if (bitstreamFetch_rdy) begin
        out_vld_q  <= 1'b0;
      end

      if (wr_en) begin
        fifo_q[wr_ptr_q] <= mem_rd_data;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_word) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop_word})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      if (grant) req_cnt_q <= req_cnt_q + LEN_W'(1);
      case ({grant, wr_en})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase

      if (pop_byte) begin
        raw_cnt_q  <= raw_cnt_q + LEN_W'(1);
        byte_idx_q <= pop_word ? 2'd0 : byte_idx_q + 2'd1;
      end
      zero_run_q <= zero_run_d;

      done_q <= 1'b0;
      case (state_q)
        IDLE:  ;
        FETCH: if (req_cnt_q == words_total_q) state_q <= DRAIN;
        DRAIN: begin
          // Wait until the last emitted byte has left the output stage.
          if ((raw_cnt_q == len_q) && out_free) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Launch overrides the per-cycle updates above.
      if (start_ok) begin
        state_q       <= FETCH;
        busy_q        <= 1'b1;
        base_q        <= base_addr;
        len_q         <= byte_len;
        epb_q         <= epb_en;
        words_total_q <= (byte_len >> 2) + LEN_W'(|byte_len[1:0]);
        req_cnt_q     <= '0;
        raw_cnt_q     <= '0;
        outstanding_q <= '0;
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        fifo_cnt_q    <= '0;
        byte_idx_q    <= '0;
        zero_run_q    <= '0;
      end
    end
  end

  assign bitstreamFetch     = out_data_q;
  assign bitstreamFetch_vld = out_vld_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_qdec_bitstream_fetch.sv
// Scoreboard bench for qdec_bitstream_fetch: a bench-side model computes the
// expected byte stream and request addresses at each start; a RAM model with
// configurable latency and random grants returns data; outputs are sampled
// on the falling edge.
module tb_qdec_bitstream_fetch;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 24;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  byte_len = '0;
  logic              epb_en = 1'b0;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_gnt = 1'b0;
  logic [31:0]       mem_rd_data = '0;
  logic              mem_rd_data_vld = 1'b0;
  logic [7:0]        bitstreamFetch;
  logic              bitstreamFetch_vld;
  logic              bitstreamFetch_rdy = 1'b1;
  logic              busy;
  logic              done;

  qdec_bitstream_fetch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .byte_len(byte_len), .epb_en(epb_en), .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt), .mem_rd_data(mem_rd_data),
    .mem_rd_data_vld(mem_rd_data_vld), .bitstreamFetch(bitstreamFetch),
    .bitstreamFetch_vld(bitstreamFetch_vld), .bitstreamFetch_rdy(bitstreamFetch_rdy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct { logic [31:0] addr; int due; } rd_t;
  rd_t         mq[$];
  logic [7:0]  exp_b[$];
  logic [31:0] exp_a[$];
  logic [31:0] ram [0:255];

  int lat = 2;
  bit gnt_rand = 0, rdy_pat = 0, occ_chk = 0, mem_rst = 0;
  int n_req, n_hs, done_cnt, first_dv, first_hs, last_hs, done_cyc, t_start;

  task automatic clr_stats();
    n_req = 0; n_hs = 0; done_cnt = 0; first_dv = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
  endtask

  // RAM model, output scoreboard and protocol checks, all on the falling edge.
  initial begin
    bit pend_req = 0; logic [31:0] pend_addr = '0;
    bit stall = 0; logic [7:0] stall_data = '0;
    rd_t r;
    forever begin
      @(negedge clk);
      if (!rst_n || mem_rst) begin
        mem_rd_gnt = 0; mem_rd_data_vld = 0; mq.delete(); pend_req = 0; stall = 0;
        continue;
      end
      bitstreamFetch_rdy = rdy_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (pend_req) begin
        chk("req_hold", mem_rd_req, 1);
        chk("addr_hold", mem_rd_addr, pend_addr);
      end
      mem_rd_gnt = mem_rd_req && (!gnt_rand || ($urandom_range(0, 1) == 1));
      if (mem_rd_gnt) begin
        n_req++;
        if (exp_a.size() == 0) chk("unexpected_req", mem_rd_addr, 32'hFFFF_FFFF);
        else chk("req_addr", mem_rd_addr, exp_a.pop_front());
        r.addr = mem_rd_addr; r.due = cyc + lat;
        mq.push_back(r);
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        mem_rd_data_vld = 1; mem_rd_data = ram[r.addr[9:2]];
        if (first_dv < 0) first_dv = cyc;
      end else begin
        mem_rd_data_vld = 0; mem_rd_data = $urandom;
      end
      pend_req = mem_rd_req && !mem_rd_gnt; pend_addr = mem_rd_addr;

      if (stall) chk("out_hold", {23'd0, bitstreamFetch_vld, bitstreamFetch}, {23'd0, 1'b1, stall_data});
      if (bitstreamFetch_vld && bitstreamFetch_rdy) begin
        if (exp_b.size() == 0) chk("extra_byte", bitstreamFetch, 32'h100);
        else chk("byte", bitstreamFetch, exp_b.pop_front());
        n_hs++; if (first_hs < 0) first_hs = cyc; last_hs = cyc;
      end
      stall = bitstreamFetch_vld && !bitstreamFetch_rdy; stall_data = bitstreamFetch;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (occ_chk) chk("occupancy", (int'(dut.fifo_cnt_q) + int'(dut.outstanding_q)) <= DEPTH, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference model: expected bytes and request addresses for one slice.
  task automatic push_slice(input logic [31:0] base, input int len, input bit epb);
    int zr = 0; logic [31:0] w; logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      w = ram[8'((base >> 2) + 32'(i / 4))];
      b = 8'(w >> (8 * (3 - (i % 4))));
      if (epb && b == 8'h03 && zr == 2) zr = 0;
      else begin
        exp_b.push_back(b);
        zr = (b == 8'h00) ? ((zr == 2) ? 2 : zr + 1) : 0;
      end
    end
    for (int i = 0; i < (len + 3) / 4; i++) exp_a.push_back(base + 32'(4 * i));
  endtask

  // Caller is 1 time unit after a rising edge; start is high for this cycle.
  task automatic go(input logic [31:0] base, input int len, input bit epb);
    base_addr = base; byte_len = LEN_W'(len); epb_en = epb; start = 1;
    push_slice(base, len, epb);
    t_start = cyc;
    tick(1);
    start = 0; base_addr = $urandom; byte_len = LEN_W'($urandom); epb_en = 1'($urandom);
  endtask

  task automatic wait_done(input int max, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (done) begin
        dcyc = cyc;
        chk("busy_low_at_done", busy, 0);
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, mem_rd_req, 0);
    chk({tag, "_addr"}, mem_rd_addr, 0);
    chk({tag, "_data"}, bitstreamFetch, 0);
    chk({tag, "_vld"}, bitstreamFetch_vld, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d, d1, sel;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[8'h40] = 32'h11223344; ram[8'h41] = 32'h55667788;
    ram[8'h80] = 32'h00000301; ram[8'h81] = 32'h00000303;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++) begin
        sel = $urandom_range(0, 3);
        ram[8'hC0 + i][8*k +: 8] = (sel < 2) ? 8'h00 : (sel == 2) ? 8'h03 : 8'($urandom);
      end
    clr_stats();

    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1; tick(2);

    // basic ordering
    clr_stats(); go(32'h100, 8, 0); wait_done(200, d); tick(4);
    chk("basic_nreq", n_req, 2);
    chk("basic_nbytes", n_hs, 8);
    chk("basic_consecutive", last_hs - first_hs, 7);
    chk("basic_first_latency", first_hs - first_dv, 2);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_sb_empty", exp_b.size() + exp_a.size(), 0);

    // partial last word
    clr_stats(); go(32'h100, 6, 0); wait_done(200, d); tick(4);
    chk("partial_nreq", n_req, 2);
    chk("partial_nbytes", n_hs, 6);
    chk("partial_done_after_last", last_hs < done_cyc, 1);
    chk("partial_done_cnt", done_cnt, 1);
    chk("partial_sb_empty", exp_b.size() + exp_a.size(), 0);

    // emulation prevention on and off
    clr_stats(); go(32'h200, 8, 1); wait_done(200, d); tick(4);
    chk("epb_on_nbytes", n_hs, 6);
    chk("epb_on_sb_empty", exp_b.size() + exp_a.size(), 0);
    clr_stats(); go(32'h200, 8, 0); wait_done(200, d); tick(4);
    chk("epb_off_nbytes", n_hs, 8);
    chk("epb_off_sb_empty", exp_b.size() + exp_a.size(), 0);

    // backpressure, slow RAM, random grants
    lat = 5; gnt_rand = 1; rdy_pat = 1; occ_chk = 1;
    clr_stats(); go(32'h300, 24, 1); wait_done(3000, d); tick(6);
    chk("bp_nreq", n_req, 6);
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_sb_empty", exp_b.size() + exp_a.size(), 0);
    clr_stats(); go(32'h304, 21, 0); wait_done(3000, d); tick(6);
    chk("bp2_nbytes", n_hs, 21);
    chk("bp2_sb_empty", exp_b.size() + exp_a.size(), 0);
    lat = 2; gnt_rand = 0; rdy_pat = 0; occ_chk = 0;

    // zero length
    clr_stats(); go(32'h100, 0, 0); wait_done(50, d); tick(4);
    chk("len0_latency", d - t_start, 3);
    chk("len0_nreq", n_req, 0);
    chk("len0_done_cnt", done_cnt, 1);

    // start while busy is ignored
    clr_stats(); go(32'h100, 8, 0); tick(3);
    chk("busy_mid", busy, 1);
    base_addr = 32'h200; byte_len = 8; epb_en = 1; start = 1; tick(1); start = 0;
    wait_done(200, d); tick(4);
    chk("ignored_nreq", n_req, 2);
    chk("ignored_nbytes", n_hs, 8);
    chk("ignored_done_cnt", done_cnt, 1);
    chk("ignored_sb_empty", exp_b.size() + exp_a.size(), 0);

    // back-to-back: start on the done cycle
    clr_stats(); go(32'h100, 8, 0); wait_done(200, d1);
    go(32'h200, 8, 1);
    chk("b2b_busy", busy, 1);
    wait_done(200, d); tick(4);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_nbytes", n_hs, 14);
    chk("b2b_nreq", n_req, 4);
    chk("b2b_sb_empty", exp_b.size() + exp_a.size(), 0);

    // reset after the third byte
    clr_stats(); go(32'h100, 8, 0);
    for (int i = 0; i < 200 && n_hs < 3; i++) tick(1);
    chk("rst_saw_3_bytes", n_hs, 3);
    rst_n = 0; mem_rst = 1; tick(1);
    chk_reset_outputs("midrst");
    tick(1);
    rst_n = 1; exp_b.delete(); exp_a.delete(); tick(1); mem_rst = 0; tick(1);
    clr_stats(); go(32'h100, 8, 0); wait_done(200, d); tick(4);
    chk("after_rst_nbytes", n_hs, 8);
    chk("after_rst_nreq", n_req, 2);
    chk("after_rst_sb_empty", exp_b.size() + exp_a.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
